// File: rtl/edge_pack_pkg.sv
// Shared types and helpers for the edge frame packer: FSM states, the FIFO
// entry layout and the bytes-per-line calculation.
package edge_pack_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   typedef struct packed {
      logic       tuser;
      logic       tlast;
      logic [7:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   function automatic int bytes_per_line(input int h_res);
      return (h_res + 7) / 8;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// Total capacity is DEPTH entries, counting the word held in the output register.
module sync_fifo_fwft #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] out_data,
   output logic             empty,
   output logic             full
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      mem_count;
   logic             out_valid;
   logic             pop;
   logic             push_ok;
   logic             refill;
   logic             from_mem;
   logic             bypass;
   logic             mem_write;

   assign pop       = out_valid & ready;
   assign full      = (count == FULL_CNT);
   assign empty     = ~out_valid;
   assign push_ok   = push & (~full | pop);
   assign mem_count = count - {{AW{1'b0}}, out_valid};
   assign refill    = ~out_valid | pop;
   assign from_mem  = refill & (mem_count != '0);
   // An empty backing store lets a new word go straight into the output register.
   assign bypass    = refill & (mem_count == '0) & push_ok;
   assign mem_write = push_ok & ~bypass;

   always_ff @(posedge clk) begin
      if (mem_write) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (mem_write) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (from_mem) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + AW'(1);
         end else if (bypass) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
         end else if (refill) begin
            out_valid <= 1'b0;
         end
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      end
   end

endmodule

// File: rtl/edge_frame_packer.sv
// Captures one binarized frame of the Canny edge stream on request, packs
// 8 pixels per byte (MSB leftmost) and streams the bytes out with SOF/EOF tags.
module edge_frame_packer
   import edge_pack_pkg::*;
#(
   parameter int H_RES      = 172,
   parameter int V_RES      = 120,
   parameter int THRESH     = 128,
   parameter int FIFO_DEPTH = 32
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_vsync,
   input  logic       i_hsync,
   input  logic       i_de,
   input  logic [7:0] i_data,
   input  logic       i_capture,
   output logic [7:0] o_tdata,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_tuser,
   output logic       o_tlast,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_overflow,
   output logic       o_short
);

   localparam int BPL    = bytes_per_line(H_RES);
   localparam int COL_W  = $clog2(H_RES + 1);
   localparam int ROW_W  = $clog2(V_RES + 1);
   localparam int BIDX_W = $clog2(BPL + 1);

   localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_RES);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPL - 1);
   localparam logic [7:0]        THRESH_V  = 8'(THRESH);

   state_t            state;
   state_t            state_next;
   logic              arm_evt;
   logic              start_evt;
   logic              frame_end;
   logic              short_evt;

   logic              vsync_prev;
   logic              de_prev;
   logic              vsync_rise;
   logic              de_fall;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [BIDX_W-1:0] byte_idx;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic [7:0]        shift_next;
   logic [7:0]        pad_data;
   logic              first_pending;

   logic              capture_act;
   logic              pix_take;
   logic              pix_bit;
   logic              last_row;
   logic              tag_last;
   logic              emit;

   logic              byte_valid;
   fifo_entry_t       byte_entry;
   fifo_entry_t       out_entry;
   logic              fifo_empty;
   logic              fifo_full;
   logic              drop;

   // Line sync carries no information here; only de delimits lines.
   logic              unused_hsync;
   assign unused_hsync = i_hsync;

   assign vsync_rise  = i_vsync & ~vsync_prev;
   assign de_fall     = de_prev & ~i_de;
   assign capture_act = (state == CAPTURE) & ~short_evt;
   assign pix_take    = (state == CAPTURE) & i_de & (col < COL_END);
   assign pix_bit     = (i_data >= THRESH_V);
   assign shift_next  = {shift[6:0], pix_bit};
   assign pad_data    = shift << (4'd8 - {1'b0, bit_cnt});
   assign last_row    = (row == ROW_LAST);
   assign tag_last    = last_row & (byte_idx == BIDX_LAST);
   assign emit        = capture_act &
                        ((pix_take & (bit_cnt == 3'd7)) | (de_fall & (bit_cnt != 3'd0)));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      arm_evt    = 1'b0;
      start_evt  = 1'b0;
      frame_end  = 1'b0;
      short_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_capture) begin
               state_next = ARM;
               arm_evt    = 1'b1;
            end
         end
         ARM: begin
            if (vsync_rise) begin
               state_next = CAPTURE;
               start_evt  = 1'b1;
            end
         end
         CAPTURE: begin
            // Completing the final row wins over a coincident vsync edge.
            if (de_fall && last_row) begin
               state_next = IDLE;
               frame_end  = 1'b1;
            end else if (vsync_rise) begin
               state_next = IDLE;
               short_evt  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vsync_prev    <= 1'b0;
         de_prev       <= 1'b0;
         col           <= '0;
         row           <= '0;
         byte_idx      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         first_pending <= 1'b0;
         byte_valid    <= 1'b0;
         byte_entry    <= '0;
      end else begin
         vsync_prev <= i_vsync;
         de_prev    <= i_de;
         byte_valid <= emit;
         if (emit) begin
            byte_entry.tuser <= first_pending;
            byte_entry.tlast <= tag_last;
            byte_entry.data  <= pix_take ? shift_next : pad_data;
            first_pending    <= 1'b0;
         end
         if (start_evt) begin
            col           <= '0;
            row           <= '0;
            byte_idx      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            first_pending <= 1'b1;
         end else if (capture_act && pix_take) begin
            col   <= col + COL_W'(1);
            shift <= shift_next;
            if (bit_cnt == 3'd7) begin
               bit_cnt  <= '0;
               byte_idx <= byte_idx + BIDX_W'(1);
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
            end
         end else if (capture_act && de_fall) begin
            col      <= '0;
            row      <= row + ROW_W'(1);
            byte_idx <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
         end
      end
   end

   // A full FIFO only accepts a byte when the sink takes one in the same cycle.
   assign drop = byte_valid & fifo_full & ~(o_tvalid & i_tready);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_done     <= 1'b0;
         o_short    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_done <= frame_end;
         if (arm_evt) begin
            o_short    <= 1'b0;
            o_overflow <= 1'b0;
         end else begin
            if (short_evt) begin
               o_short <= 1'b1;
            end
            if (drop) begin
               o_overflow <= 1'b1;
            end
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (byte_valid),
      .push_data (byte_entry),
      .ready     (i_tready),
      .out_data  (out_entry),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign o_tvalid = ~fifo_empty;
   assign o_tdata  = out_entry.data;
   assign o_tuser  = out_entry.tuser;
   assign o_tlast  = out_entry.tlast;
   assign o_busy   = (state == ARM) || (state == CAPTURE);

endmodule

// File: tb/tb_edge_frame_packer.sv
// Directed bench for edge_frame_packer: spot-check table on a nominal frame plus
// overflow, short-frame/threshold, mid-capture reset and backpressure sequences.
module tb_edge_frame_packer;

   localparam int H_RES       = 172;
   localparam int V_RES       = 120;
   localparam int BPL         = 22;
   localparam int FRAME_BYTES = 2640;
   localparam int BLANK       = 2;

   logic       clk       = 1'b0;
   logic       rstn      = 1'b0;
   logic       i_vsync   = 1'b0;
   logic       i_hsync   = 1'b0;
   logic       i_de      = 1'b0;
   logic [7:0] i_data    = 8'd0;
   logic       i_capture = 1'b0;
   logic       i_tready  = 1'b0;
   logic [7:0] o_tdata;
   logic       o_tvalid;
   logic       o_tuser;
   logic       o_tlast;
   logic       o_busy;
   logic       o_done;
   logic       o_overflow;
   logic       o_short;

   edge_frame_packer #(
      .H_RES      (H_RES),
      .V_RES      (V_RES),
      .THRESH     (128),
      .FIFO_DEPTH (32)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_vsync    (i_vsync),
      .i_hsync    (i_hsync),
      .i_de       (i_de),
      .i_data     (i_data),
      .i_capture  (i_capture),
      .o_tdata    (o_tdata),
      .o_tvalid   (o_tvalid),
      .i_tready   (i_tready),
      .o_tuser    (o_tuser),
      .o_tlast    (o_tlast),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overflow (o_overflow),
      .o_short    (o_short)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       tuser;
      logic       tlast;
   } vec_t;

   vec_t       vecs[8];
   logic [9:0] cap_q[$];
   int         cyc            = 0;
   int         done_cnt       = 0;
   int         done_busy_err  = 0;
   int         stall_err      = 0;
   int         first_valid_cyc = -1;
   int         pix7_cyc       = 0;
   int         ready_mode     = 0;
   int         pass_cnt       = 0;
   int         total_cnt      = 0;
   logic       prev_stall     = 1'b0;
   logic       prev_busy      = 1'b0;
   logic [9:0] prev_word      = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: records accepted bytes and watches handshake/pulse rules.
   always @(negedge clk) begin
      if (rstn && o_tvalid && first_valid_cyc < 0) first_valid_cyc <= cyc;
      if (prev_stall && (!o_tvalid || {o_tuser, o_tlast, o_tdata} != prev_word))
         stall_err <= stall_err + 1;
      if (rstn && o_tvalid && i_tready) cap_q.push_back({o_tuser, o_tlast, o_tdata});
      if (o_done) begin
         done_cnt <= done_cnt + 1;
         if (!prev_busy || o_busy) done_busy_err <= done_busy_err + 1;
      end
      prev_stall <= rstn && o_tvalid && !i_tready;
      prev_word  <= {o_tuser, o_tlast, o_tdata};
      prev_busy  <= o_busy;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       i_tready = 1'b1;
            1:       i_tready = ~i_tready;
            default: i_tready = 1'b0;
         endcase
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
   endtask

   task automatic pulse_capture();
      i_capture = 1'b1;
      step(1);
      i_capture = 1'b0;
   endtask

   // mode 0: alternating 255/0; mode 1: first line is 127,128 then zeros.
   task automatic applyStimulus(input int lines, input int mode, input bit end_vsync);
      i_vsync = 1'b1;
      step(2);
      i_vsync = 1'b0;
      step(2);
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < H_RES; c++) begin
            i_de = 1'b1;
            if (mode == 1 && l == 0) i_data = (c == 0) ? 8'd127 : (c == 1) ? 8'd128 : 8'd0;
            else i_data = (c % 2 == 0) ? 8'd255 : 8'd0;
            if (l == 0 && c == 7) pix7_cyc = cyc;
            step(1);
         end
         i_de    = 1'b0;
         i_data  = 8'd0;
         i_hsync = 1'b1;
         step(1);
         i_hsync = 1'b0;
         step(BLANK - 1);
      end
      if (end_vsync) begin
         i_vsync = 1'b1;
         step(2);
         i_vsync = 1'b0;
         step(2);
      end
   endtask

   task automatic wait_bytes(input int base, input int n, input int limit);
      int k = 0;
      while (cap_q.size() - base < n && k < limit) begin
         step(1);
         k++;
      end
      step(40);
   endtask

   function automatic logic [9:0] exp_word(input int idx, input int mode, input int last_idx);
      logic [7:0] d;
      int line;
      int b;
      line = idx / BPL;
      b    = idx % BPL;
      if (mode == 1 && line == 0) d = (b == 0) ? 8'h40 : 8'h00;
      else d = (b == BPL - 1) ? 8'hA0 : 8'hAA;
      return {idx == 0, idx == last_idx, d};
   endfunction

   function automatic int seq_errors(input int base, input int n, input int mode, input int last_idx);
      int err = 0;
      for (int i = 0; i < n; i++) begin
         if (base + i >= cap_q.size()) err++;
         else if (cap_q[base + i] != exp_word(i, mode, last_idx)) err++;
      end
      return err;
   endfunction

   initial begin
      int q0;
      int d0;
      int e0;
      int word;

      vecs[0] = '{0,    8'hAA, 1'b1, 1'b0};
      vecs[1] = '{1,    8'hAA, 1'b0, 1'b0};
      vecs[2] = '{20,   8'hAA, 1'b0, 1'b0};
      vecs[3] = '{21,   8'hA0, 1'b0, 1'b0};
      vecs[4] = '{22,   8'hAA, 1'b0, 1'b0};
      vecs[5] = '{43,   8'hA0, 1'b0, 1'b0};
      vecs[6] = '{2638, 8'hAA, 1'b0, 1'b0};
      vecs[7] = '{2639, 8'hA0, 1'b0, 1'b1};

      ready_mode = 0;
      rstn = 1'b0;
      step(3);
      checkOutput("reset_tvalid",   o_tvalid,   0);
      checkOutput("reset_busy",     o_busy,     0);
      checkOutput("reset_done",     o_done,     0);
      checkOutput("reset_overflow", o_overflow, 0);
      checkOutput("reset_short",    o_short,    0);
      rstn = 1'b1;
      step(3);

      // Nominal frame with an always-ready sink
      q0 = cap_q.size();
      d0 = done_cnt;
      e0 = done_busy_err;
      pulse_capture();
      applyStimulus(V_RES, 0, 1'b0);
      wait_bytes(q0, FRAME_BYTES, 200);
      checkOutput("nom_count", cap_q.size() - q0, FRAME_BYTES);
      checkOutput("nom_seq_errors", seq_errors(q0, FRAME_BYTES, 0, FRAME_BYTES - 1), 0);
      for (int i = 0; i < 8; i++) begin
         word = -1;
         if (q0 + vecs[i].idx < cap_q.size()) word = int'(cap_q[q0 + vecs[i].idx]);
         checkOutput($sformatf("nom_byte%0d", vecs[i].idx), word,
                     int'({vecs[i].tuser, vecs[i].tlast, vecs[i].data}));
      end
      checkOutput("nom_done_pulses", done_cnt - d0, 1);
      checkOutput("nom_done_busy_drop", done_busy_err - e0, 0);
      checkOutput("first_byte_latency", first_valid_cyc - pix7_cyc, 2);
      checkOutput("nom_overflow", o_overflow, 0);
      checkOutput("nom_short", o_short, 0);
      checkOutput("nom_idle_busy", o_busy, 0);

      // Overflow: sink stalled for the whole frame
      ready_mode = 2;
      step(2);
      q0 = cap_q.size();
      d0 = done_cnt;
      pulse_capture();
      applyStimulus(V_RES, 0, 1'b0);
      checkOutput("ovf_flag", o_overflow, 1);
      checkOutput("ovf_done_pulses", done_cnt - d0, 1);
      checkOutput("ovf_tvalid", o_tvalid, 1);
      ready_mode = 0;
      wait_bytes(q0, 32, 100);
      checkOutput("ovf_retained", cap_q.size() - q0, 32);
      checkOutput("ovf_seq_errors", seq_errors(q0, 32, 0, -1), 0);

      // Short frame carrying the threshold-edge pattern on its first line
      q0 = cap_q.size();
      d0 = done_cnt;
      pulse_capture();
      checkOutput("capture_clears_ovf", o_overflow, 0);
      checkOutput("arm_busy", o_busy, 1);
      applyStimulus(50, 1, 1'b1);
      checkOutput("short_flag", o_short, 1);
      checkOutput("short_idle", o_busy, 0);
      checkOutput("short_no_done", done_cnt - d0, 0);
      wait_bytes(q0, 1100, 200);
      checkOutput("short_count", cap_q.size() - q0, 1100);
      word = -1;
      if (q0 < cap_q.size()) word = int'(cap_q[q0][7:0]);
      checkOutput("thresh_first_byte", word, 8'h40);
      checkOutput("short_seq_errors", seq_errors(q0, 1100, 1, -1), 0);

      // Reset at line 30 with the FIFO full and flags set
      ready_mode = 2;
      step(1);
      pulse_capture();
      checkOutput("capture_clears_short", o_short, 0);
      applyStimulus(30, 0, 1'b0);
      checkOutput("pre_reset_tvalid", o_tvalid, 1);
      checkOutput("pre_reset_ovf", o_overflow, 1);
      rstn = 1'b0;
      step(1);
      rstn = 1'b1;
      checkOutput("post_reset_tvalid", o_tvalid, 0);
      checkOutput("post_reset_ovf", o_overflow, 0);
      checkOutput("post_reset_busy", o_busy, 0);
      checkOutput("post_reset_short", o_short, 0);
      step(2);

      // Clean frame after reset with a sink that toggles ready every cycle
      ready_mode = 1;
      q0 = cap_q.size();
      d0 = done_cnt;
      pulse_capture();
      applyStimulus(V_RES, 0, 1'b0);
      wait_bytes(q0, FRAME_BYTES, 400);
      checkOutput("bp_count", cap_q.size() - q0, FRAME_BYTES);
      checkOutput("bp_seq_errors", seq_errors(q0, FRAME_BYTES, 0, FRAME_BYTES - 1), 0);
      checkOutput("bp_overflow", o_overflow, 0);
      checkOutput("bp_done_pulses", done_cnt - d0, 1);
      checkOutput("stall_hold_errors", stall_err, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
